// File: rtl/sig_logic_array.sv
// sig_logic_array: pairwise logic stage for the general-purpose signal header.
// Each channel synchronises and glitch-filters two raw inputs, combines them
// with a selectable NAND/AND/OR/XOR and registers the result. Per-channel
// rising-edge counters with a sticky saturation flag are read through cnt_sel.
module sig_logic_array #(
    parameter int NUM_CH   = 4,
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = 2
) (
    input  logic                sys_clock,
    input  logic                reset,
    input  logic [2*NUM_CH-1:0] sig_in,
    input  logic [2*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]   sig_out,
    input  logic [SEL_W-1:0]    cnt_sel,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    cnt_val,
    output logic                cnt_ovf
);
    localparam int IN_W = 2 * NUM_CH;
    localparam int FC_W = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IN_W-1:0]   sync1_q, sync1_d;
    logic [IN_W-1:0]   sync2_q, sync2_d;
    logic [IN_W-1:0]   filt;
    logic [NUM_CH-1:0] sig_out_q, sig_out_d;
    logic [NUM_CH-1:0] out_prev_q, out_prev_d;  // previous-output register
    logic [NUM_CH-1:0] rise;
    logic              run_q, run_d;             // set on the reset-release edge
    logic              arm_q, arm_d;             // set one cycle later
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_val_q, cnt_val_d;
    logic              cnt_ovf_q, cnt_ovf_d;

    // Two-flop synchroniser next-state for every raw input bit.
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_no_filt
            assign filt = sync2_q;
        end else begin : g_filt
            logic [IN_W-1:0] filt_q, filt_d;
            logic [FC_W-1:0] fcnt_q [IN_W];
            logic [FC_W-1:0] fcnt_d [IN_W];

            // Filtered bit follows the synced bit only after FILT_LEN
            // consecutive disagreeing samples; any agreement restarts the run.
            always_comb begin
                filt_d = filt_q;
                for (int b = 0; b < IN_W; b++) begin
                    fcnt_d[b] = '0;
                    if (sync2_q[b] != filt_q[b]) begin
                        if (fcnt_q[b] == FC_W'(FILT_LEN - 1)) begin
                            filt_d[b] = sync2_q[b];
                        end else begin
                            fcnt_d[b] = fcnt_q[b] + 1'b1;
                        end
                    end
                end
            end

            // Filter value and stability counters.
            always_ff @(posedge sys_clock) begin
                if (reset) begin
                    filt_q <= '0;
                    fcnt_q <= '{default: '0};
                end else begin
                    filt_q <= filt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    // Per-channel function of the filtered pair; mode is used live each cycle.
    always_comb begin
        sig_out_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode[2*k +: 2])
                2'b00:   sig_out_d[k] = ~(filt[2*k+1] & filt[2*k]);
                2'b01:   sig_out_d[k] = filt[2*k+1] & filt[2*k];
                2'b10:   sig_out_d[k] = filt[2*k+1] | filt[2*k];
                default: sig_out_d[k] = filt[2*k+1] ^ filt[2*k];
            endcase
        end
    end

    // Edge counters: the arm flag lags reset release by two edges so the
    // forced post-reset NAND rise is never counted; clear beats a rise.
    always_comb begin
        out_prev_d = sig_out_q;
        rise       = sig_out_q & ~out_prev_q;
        run_d      = 1'b1;
        arm_d      = run_q;
        cnt_val_d  = '0;
        cnt_ovf_d  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (cnt_clr && (cnt_sel == SEL_W'(k))) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (arm_q && rise[k]) begin
                if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end else begin
                    ovf_d[k] = 1'b1;
                end
            end
            // Readback shows the counter as it stood before this edge.
            if (cnt_sel == SEL_W'(k)) begin
                cnt_val_d = cnt_q[k];
                cnt_ovf_d = ovf_q[k];
            end
        end
    end

    // Output, edge-detect, counter and readback registers.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            sig_out_q  <= '0;
            out_prev_q <= '0;
            run_q      <= 1'b0;
            arm_q      <= 1'b0;
            cnt_q      <= '{default: '0};
            ovf_q      <= '0;
            cnt_val_q  <= '0;
            cnt_ovf_q  <= 1'b0;
        end else begin
            sig_out_q  <= sig_out_d;
            out_prev_q <= out_prev_d;
            run_q      <= run_d;
            arm_q      <= arm_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            cnt_val_q  <= cnt_val_d;
            cnt_ovf_q  <= cnt_ovf_d;
        end
    end

    assign sig_out = sig_out_q;
    assign cnt_val = cnt_val_q;
    assign cnt_ovf = cnt_ovf_q;

endmodule

// File: tb/tb_sig_logic_array.sv
// Testbench for sig_logic_array: directed steps followed by random traffic,
// every cycle compared against a behavioural model through an expected queue.
module tb_sig_logic_array;
    localparam int N  = 3;
    localparam int FL = 4;
    localparam int CW = 4;
    localparam int SW = 2;
    localparam int IW = 2 * N;
    localparam int EW = N + CW + 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          sys_clock;
    logic          reset;
    logic [IW-1:0] sig_in;
    logic [IW-1:0] mode;
    logic [N-1:0]  sig_out;
    logic [SW-1:0] cnt_sel;
    logic          cnt_clr;
    logic [CW-1:0] cnt_val;
    logic          cnt_ovf;

    int tests = 0;
    int fails = 0;

    sig_logic_array #(
        .NUM_CH(N), .FILT_LEN(FL), .CNT_W(CW), .SEL_W(SW)
    ) dut (
        .sys_clock(sys_clock),
        .reset    (reset),
        .sig_in   (sig_in),
        .mode     (mode),
        .sig_out  (sig_out),
        .cnt_sel  (cnt_sel),
        .cnt_clr  (cnt_clr),
        .cnt_val  (cnt_val),
        .cnt_ovf  (cnt_ovf)
    );

    // ---------------- clock / watchdog ----------------
    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // Inputs reach the filter two edges after being applied; a filtered bit
    // adopts a value once the last FL synced samples all agree on it.
    logic [IW-1:0] m_pipe[$];
    logic [IW-1:0] m_win[$];
    logic [IW-1:0] m_filt;
    logic [N-1:0]  m_out, m_prev;
    int            m_cnt[N];
    bit            m_ovf[N];
    int            m_idx;          // non-reset edges since the last reset
    logic [CW-1:0] m_val;
    logic          m_vovf;
    logic [EW-1:0] exp_q[$];

    function automatic logic fn(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'b00:   return !(a && b);
            2'b01:   return a && b;
            2'b10:   return a || b;
            default: return a != b;
        endcase
    endfunction

    task automatic model_edge();
        logic [IW-1:0] s;
        logic [N-1:0]  out_new;
        bit            same;
        int            sel_i;
        if (reset) begin
            m_pipe = {IW'(0), IW'(0)};
            m_win.delete();
            m_filt = '0;
            m_out  = '0;
            m_prev = '0;
            for (int k = 0; k < N; k++) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
            end
            m_idx  = 0;
            m_val  = '0;
            m_vovf = 1'b0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(sig_in);
            for (int k = 0; k < N; k++)
                out_new[k] = fn(mode[2*k +: 2], m_filt[2*k+1], m_filt[2*k]);
            sel_i = int'(cnt_sel);
            if (sel_i < N) begin
                m_val  = CW'(m_cnt[sel_i]);
                m_vovf = m_ovf[sel_i];
            end else begin
                m_val  = '0;
                m_vovf = 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (cnt_clr && sel_i == k) begin
                    m_cnt[k] = 0;
                    m_ovf[k] = 0;
                end else if (m_out[k] && !m_prev[k] && m_idx >= 2) begin
                    if (m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
                    else m_ovf[k] = 1;
                end
            end
            m_prev = m_out;
            m_out  = out_new;
            m_win.push_back(s);
            if (m_win.size() > FL) void'(m_win.pop_front());
            if (m_win.size() == FL) begin
                for (int b = 0; b < IW; b++) begin
                    same = 1;
                    foreach (m_win[j]) if (m_win[j][b] !== s[b]) same = 0;
                    if (same) m_filt[b] = s[b];
                end
            end
            if (m_idx < 2) m_idx = m_idx + 1;
        end
        exp_q.push_back({m_out, m_val, m_vovf});
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("sig_out", 32'(sig_out), 32'(e[EW-1 -: N]));
        chk("cnt_val", 32'(cnt_val), 32'(e[CW:1]));
        chk("cnt_ovf", 32'(cnt_ovf), 32'(e[0]));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are changed 1 time unit after an edge and sampled by the next.
    task automatic cycle();
        model_edge();
        @(posedge sys_clock);
        #1;
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_bit(input int ch, input logic val, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if (sig_out[ch] === val) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (sig_out[ch] === 1'b1) hi++;
        end
    endtask

    task automatic pulse_ch2_rise();
        mode[5:4] = 2'b01;
        cycle();
        mode[5:4] = 2'b10;
        cycle();
    endtask

    // ---------------- stimulus ----------------
    logic sweep_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   lat;
    int   hi;

    initial begin
        reset   = 1'b1;
        sig_in  = '0;
        mode    = '0;
        cnt_sel = '0;
        cnt_clr = 1'b0;
        m_pipe  = {IW'(0), IW'(0)};

        // Reset defaults and arm suppression of the post-reset NAND rise.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_sig_out", 32'(sig_out), 32'd0);
            chk("rst_cnt_val", 32'(cnt_val), 32'd0);
        end
        reset = 1'b0;
        cycle();
        chk("release_nand", 32'(sig_out), 32'b111);
        cycles(4);
        chk("arm_suppress", 32'(cnt_val), 32'd0);

        // Latency through sync, filter and output register.
        sig_in[1:0] = 2'b11;
        wait_bit(0, 1'b0, 20, lat);
        chk("lat_fall", 32'(lat), 32'd7);
        sig_in[1:0] = 2'b00;
        wait_bit(0, 1'b1, 20, lat);
        chk("lat_rise", 32'(lat), 32'd7);
        cycles(3);
        chk("ch0_count", 32'(cnt_val), 32'd1);

        // Glitch rejection on ch1 with OR.
        cnt_sel   = 2'd1;
        mode[3:2] = 2'b10;
        cycles(3);
        sig_in[2] = 1'b1;
        cycles(3);
        sig_in[2] = 1'b0;
        count_high(1, 14, hi);
        chk("glitch_hi", 32'(hi), 32'd0);
        chk("glitch_cnt", 32'(cnt_val), 32'd0);
        sig_in[2] = 1'b1;
        count_high(1, 5, hi);
        sig_in[2] = 1'b0;
        begin
            int hi2;
            count_high(1, 15, hi2);
            hi = hi + hi2;
        end
        chk("pulse_hi", 32'(hi), 32'd5);
        chk("pulse_cnt", 32'(cnt_val), 32'd1);

        // Mode sweep on ch2 with filtered pair (1,0).
        cnt_sel   = 2'd2;
        sig_in[5] = 1'b1;
        cycles(10);
        for (int m = 0; m < 4; m++) begin
            mode[5:4] = 2'(m);
            cycle();
            chk("sweep", 32'(sig_out[2]), 32'(sweep_exp[m]));
        end
        cycles(3);
        chk("sweep_cnt", 32'(cnt_val), 32'd1);

        // Saturation on ch2.
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) pulse_ch2_rise();
        cycles(3);
        chk("sat_val", 32'(cnt_val), 32'd15);
        chk("sat_ovf", 32'(cnt_ovf), 32'd1);
        for (int i = 0; i < 4; i++) pulse_ch2_rise();
        cycles(3);
        chk("hold_val", 32'(cnt_val), 32'd15);
        chk("hold_ovf", 32'(cnt_ovf), 32'd1);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        cycles(2);
        chk("clr_val", 32'(cnt_val), 32'd0);
        chk("clr_ovf", 32'(cnt_ovf), 32'd0);
        mode[5:4] = 2'b01;
        cycles(2);
        mode[5:4] = 2'b10;
        cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        cycles(2);
        chk("clr_beats_rise", 32'(cnt_val), 32'd0);

        // Out-of-range select.
        pulse_ch2_rise();
        pulse_ch2_rise();
        cnt_sel = 2'd3;
        cycles(2);
        chk("oor_val", 32'(cnt_val), 32'd0);
        chk("oor_ovf", 32'(cnt_ovf), 32'd0);
        cnt_clr = 1'b1;
        cycles(2);
        cnt_clr = 1'b0;
        cnt_sel = 2'd2;
        cycles(2);
        chk("oor_clr_noeffect", 32'(cnt_val), 32'd2);

        // Reset while a filter count is two cycles old.
        sig_in[1:0] = 2'b11;
        cycles(4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_bit(0, 1'b0, 20, lat);
        chk("reset_lat", 32'(lat), 32'd7);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0)
                sig_in = sig_in ^ (IW'(1) << $urandom_range(0, IW - 1));
            if ($urandom_range(0, 15) == 0) mode = IW'($urandom);
            if ($urandom_range(0, 7) == 0) cnt_sel = SW'($urandom);
            cnt_clr = ($urandom_range(0, 24) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset   = 1'b0;
        cnt_clr = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
